// File: rtl/cnn_layer_accel_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_stream_loader_pkg
// Shared definitions for the stream loader and its sequence generator:
//   - flag bit offsets inside a sequence word. A word is
//     {S, RM, RST, P, seq[C_SEQ_FIELD_WIDTH-1:0]}. Because the seq field
//     width is a module parameter, the flag offsets are counted from the
//     bit just above the seq field.
//   - number of words per group
//   - loader FSM state encoding
// ---------------------------------------------------------------------------
package cnn_layer_accel_stream_loader_pkg;

    localparam int GROUP_SIZE = 5;

    localparam int FLAG_WIDTH = 4;
    localparam int FLAG_P     = 0;
    localparam int FLAG_RST   = 1;
    localparam int FLAG_RM    = 2;
    localparam int FLAG_S     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ,
        ST_GAP,
        ST_PIX,
        ST_DONE
    } loader_state_t;

    function automatic logic [FLAG_WIDTH-1:0] make_flags(input logic s,
                                                         input logic rm,
                                                         input logic rst,
                                                         input logic p);
        logic [FLAG_WIDTH-1:0] f;
        f           = '0;
        f[FLAG_S]   = s;
        f[FLAG_RM]  = rm;
        f[FLAG_RST] = rst;
        f[FLAG_P]   = p;
        return f;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_stream_loader_seq_gen.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_seq_gen
// Generates the sequence table one word at a time.
// Keeps one seq-field register per word position within a group. Each
// register always holds the value for the group that is currently being
// emitted at that position. A group counter and its parity bit drive the
// flag bits and the zero fill after the last content group.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   init             load group-0 values and latch the column/kernel config
//   advance          current word was accepted; step to the next word
//   num_cols_cfg     columns minus 1
//   kernel_size_cfg  kernel size K
//   word             current sequence word {S,RM,RST,P,seq}
//   last_word        current word is the final word of the table
// ---------------------------------------------------------------------------
module cnn_layer_accel_seq_gen
    import cnn_layer_accel_stream_loader_pkg::*;
#(
    parameter int C_SEQ_FIELD_WIDTH = 10,
    parameter int C_BANK_OFFSET     = 512,
    parameter int C_DIM_WIDTH       = 10
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    init,
    input  logic                                    advance,
    input  logic [C_DIM_WIDTH-1:0]                  num_cols_cfg,
    input  logic [C_DIM_WIDTH-1:0]                  kernel_size_cfg,
    output logic [C_SEQ_FIELD_WIDTH+FLAG_WIDTH-1:0] word,
    output logic                                    last_word
);

    localparam int SW = C_SEQ_FIELD_WIDTH;
    localparam logic [SW-1:0] OFF      = SW'(C_BANK_OFFSET);
    localparam logic [2:0]    LAST_POS = 3'(GROUP_SIZE - 1);

    logic [SW-1:0]          seq_reg [GROUP_SIZE];
    logic [2:0]             pos;
    logic [C_DIM_WIDTH:0]   grp;
    logic [C_DIM_WIDTH:0]   last_grp;
    logic [C_DIM_WIDTH-1:0] last_col;
    logic                   grp_odd;
    logic [SW-1:0]          step;
    logic [FLAG_WIDTH-1:0]  flags;

    // Position 1 adds 2 only when entering an even group, i.e. when the
    // group being left is odd. Every other position adds 1 per group.
    always_comb begin
        step = SW'(1);
        if (pos == 3'd1) begin
            step = grp_odd ? SW'(2) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GROUP_SIZE; i++) begin
                seq_reg[i] <= '0;
            end
            pos      <= '0;
            grp      <= '0;
            grp_odd  <= 1'b0;
            last_grp <= '0;
            last_col <= '0;
        end else if (init) begin
            seq_reg[0] <= '0;
            seq_reg[1] <= SW'(2);
            seq_reg[2] <= OFF;
            seq_reg[3] <= OFF + SW'(1);
            seq_reg[4] <= OFF + SW'(2);
            pos        <= '0;
            grp        <= '0;
            grp_odd    <= 1'b0;
            // Content groups are 0..cols-K. The config is already known to
            // satisfy K <= cols, so this cannot underflow.
            last_grp   <= {1'b0, num_cols_cfg} + (C_DIM_WIDTH+1)'(1)
                          - {1'b0, kernel_size_cfg};
            last_col   <= num_cols_cfg;
        end else if (advance) begin
            seq_reg[pos] <= seq_reg[pos] + step;
            if (pos == LAST_POS) begin
                pos     <= '0;
                grp     <= grp + (C_DIM_WIDTH+1)'(1);
                grp_odd <= ~grp_odd;
            end else begin
                pos <= pos + 3'd1;
            end
        end
    end

    // Word 0 carries P = (g-1)%2, which is also 1 for group 0, so ~grp_odd
    // covers every group.
    always_comb begin
        flags = '0;
        case (pos)
            3'd0:    flags = make_flags(grp != '0, 1'b0, 1'b1, ~grp_odd);
            3'd1:    flags = make_flags(1'b0, 1'b0, 1'b0, grp_odd);
            3'd2:    flags = make_flags(grp == '0, 1'b0, 1'b0, 1'b0);
            3'd4:    flags = make_flags(1'b0, 1'b1, 1'b0, 1'b0);
            default: flags = '0;
        endcase
        word      = (grp > last_grp) ? '0 : {flags, seq_reg[pos]};
        last_word = (pos == LAST_POS) && (grp == {1'b0, last_col});
    end

endmodule

// File: rtl/cnn_layer_accel_stream_loader.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_stream_loader
// Drives the accelerator's shared datain port. After a start pulse it streams
// the generated sequence table with seq_datain_tag set, inserts one idle
// cycle, and then passes the upstream pixel stream through with
// pixel_datain_tag set until rows*cols pixels have transferred.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start                              begin a load (ignored while busy)
//   num_rows_cfg, num_cols_cfg         rows-1, cols-1
//   kernel_size_cfg                    kernel size K
//   pix_in, pix_in_valid, pix_in_rdy   upstream pixel stream
//   datain, datain_valid               to the accelerator
//   seq_datain_tag, pixel_datain_tag   word type markers
//   seq_datain_rdy, pixel_datain_rdy   accelerator ready per word type
//   busy, done                         load in progress / last pixel moved
//   cfg_err                            sticky bad-config flag
// ---------------------------------------------------------------------------
module cnn_layer_accel_stream_loader
    import cnn_layer_accel_stream_loader_pkg::*;
#(
    parameter int C_PIXEL_WIDTH     = 16,
    parameter int C_SEQ_FIELD_WIDTH = 10,
    parameter int C_BANK_OFFSET     = 512,
    parameter int C_DATA_WIDTH      = 16,
    parameter int C_DIM_WIDTH       = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [C_DIM_WIDTH-1:0]   num_rows_cfg,
    input  logic [C_DIM_WIDTH-1:0]   num_cols_cfg,
    input  logic [C_DIM_WIDTH-1:0]   kernel_size_cfg,
    input  logic [C_PIXEL_WIDTH-1:0] pix_in,
    input  logic                     pix_in_valid,
    output logic                     pix_in_rdy,
    output logic [C_DATA_WIDTH-1:0]  datain,
    output logic                     datain_valid,
    output logic                     seq_datain_tag,
    output logic                     pixel_datain_tag,
    input  logic                     seq_datain_rdy,
    input  logic                     pixel_datain_rdy,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int SEQ_WORD_WIDTH = C_SEQ_FIELD_WIDTH + FLAG_WIDTH;

    loader_state_t state, next_state;

    logic [C_DIM_WIDTH-1:0]    num_rows_q;
    logic [C_DIM_WIDTH-1:0]    num_cols_q;
    logic [C_DIM_WIDTH-1:0]    row_cnt;
    logic [C_DIM_WIDTH-1:0]    col_cnt;
    logic                      cfg_bad;
    logic                      accept_start;
    logic                      seq_xfer;
    logic                      seq_last;
    logic                      pix_xfer;
    logic                      pix_last;
    logic [SEQ_WORD_WIDTH-1:0] seq_word;

    // Compare in one extra bit so cols = 2^C_DIM_WIDTH is representable.
    assign cfg_bad = (kernel_size_cfg == '0) ||
                     ({1'b0, kernel_size_cfg} >
                      ({1'b0, num_cols_cfg} + (C_DIM_WIDTH+1)'(1)));

    assign accept_start = (state == ST_IDLE) && start && !cfg_bad;
    assign seq_xfer     = (state == ST_SEQ) && seq_datain_rdy;
    assign pix_xfer     = (state == ST_PIX) && pix_in_valid && pixel_datain_rdy;
    assign pix_last     = (row_cnt == num_rows_q) && (col_cnt == num_cols_q);

    cnn_layer_accel_seq_gen #(
        .C_SEQ_FIELD_WIDTH (C_SEQ_FIELD_WIDTH),
        .C_BANK_OFFSET     (C_BANK_OFFSET),
        .C_DIM_WIDTH       (C_DIM_WIDTH)
    ) u_seq_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .init            (accept_start),
        .advance         (seq_xfer),
        .num_cols_cfg    (num_cols_cfg),
        .kernel_size_cfg (kernel_size_cfg),
        .word            (seq_word),
        .last_word       (seq_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // cfg_err only reacts to a start seen in IDLE, so a start during a load
    // neither sets nor clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err    <= 1'b0;
            num_rows_q <= '0;
            num_cols_q <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                cfg_err <= cfg_bad;
            end
            if (accept_start) begin
                num_rows_q <= num_rows_cfg;
                num_cols_q <= num_cols_cfg;
                row_cnt    <= '0;
                col_cnt    <= '0;
            end else if (pix_xfer) begin
                if (col_cnt == num_cols_q) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + C_DIM_WIDTH'(1);
                end else begin
                    col_cnt <= col_cnt + C_DIM_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        next_state       = state;
        datain           = '0;
        datain_valid     = 1'b0;
        seq_datain_tag   = 1'b0;
        pixel_datain_tag = 1'b0;
        pix_in_rdy       = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_start) begin
                    next_state = ST_SEQ;
                end
            end
            ST_SEQ: begin
                busy                         = 1'b1;
                datain_valid                 = 1'b1;
                seq_datain_tag               = 1'b1;
                datain[SEQ_WORD_WIDTH-1:0]   = seq_word;
                if (seq_xfer && seq_last) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                busy       = 1'b1;
                next_state = ST_PIX;
            end
            ST_PIX: begin
                busy                        = 1'b1;
                pixel_datain_tag            = 1'b1;
                datain[C_PIXEL_WIDTH-1:0]   = pix_in;
                datain_valid                = pix_in_valid;
                pix_in_rdy                  = pixel_datain_rdy;
                if (pix_xfer && pix_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cnn_layer_accel_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_stream_loader
// Directed bench for the stream loader. Expected sequence words come from a
// closed-form description of the table plus a few hand-computed constants;
// pixel values are generated by the bench and must come out in order.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_stream_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  num_rows_cfg;
    logic [9:0]  num_cols_cfg;
    logic [9:0]  kernel_size_cfg;
    logic [15:0] pix_in;
    logic        pix_in_valid;
    logic        pix_in_rdy;
    logic [15:0] datain;
    logic        datain_valid;
    logic        seq_datain_tag;
    logic        pixel_datain_tag;
    logic        seq_datain_rdy;
    logic        pixel_datain_rdy;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int check_count   = 0;
    int fail_count    = 0;
    int done_count    = 0;
    int expected_done = 0;

    logic [15:0] captured  [0:255];
    logic [15:0] first_run [0:255];
    logic [22:0] all_outs;

    assign all_outs = {datain, datain_valid, seq_datain_tag, pixel_datain_tag,
                       pix_in_rdy, busy, done, cfg_err};

    cnn_layer_accel_stream_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .num_rows_cfg     (num_rows_cfg),
        .num_cols_cfg     (num_cols_cfg),
        .kernel_size_cfg  (kernel_size_cfg),
        .pix_in           (pix_in),
        .pix_in_valid     (pix_in_valid),
        .pix_in_rdy       (pix_in_rdy),
        .datain           (datain),
        .datain_valid     (datain_valid),
        .seq_datain_tag   (seq_datain_tag),
        .pixel_datain_tag (pixel_datain_tag),
        .seq_datain_rdy   (seq_datain_rdy),
        .pixel_datain_rdy (pixel_datain_rdy),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Word idx of the table for the given cols/K, from the group formulas.
    function automatic logic [15:0] refWord(input int idx, input int cols, input int k);
        int g;
        int p;
        int s;
        logic [3:0] f;
        g = idx / 5;
        p = idx % 5;
        if (g > cols - k) return 16'h0000;
        case (p)
            0: begin s = g;             f = (g == 0) ? 4'b0011 : {3'b101, 1'((g - 1) % 2)}; end
            1: begin s = 2 + 2 * (g / 2); f = {3'b000, 1'(g % 2)}; end
            2: begin s = 512 + g;       f = (g == 0) ? 4'b1000 : 4'b0000; end
            3: begin s = 513 + g;       f = 4'b0000; end
            default: begin s = 514 + g; f = 4'b0100; end
        endcase
        return {2'b00, f, s[9:0]};
    endfunction

    function automatic logic [15:0] pixVal(input int i);
        return 16'(i * 37 + 16'h1000);
    endfunction

    // Present a config and a one-cycle start; returns 1 ns after the edge
    // that sampled start.
    task automatic applyStimulus(input int rows_m1, input int cols_m1, input int k);
        num_rows_cfg    = 10'(rows_m1);
        num_cols_cfg    = 10'(cols_m1);
        kernel_size_cfg = 10'(k);
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runLoad(input int rows, input int cols, input int k,
                           input bit seq_random, input bit pix_random,
                           input bit poke_start, input int abort_at);
        int seq_idx = 0;
        int pix_idx = 0;
        int cycles  = 0;
        int total   = 5 * cols;
        int npix    = rows * cols;
        bit holding = 0;
        bit poked   = 0;
        logic [15:0] held_word = '0;

        applyStimulus(rows - 1, cols - 1, k);
        checkOutput("load_start", {cfg_err, busy}, 2'b01);

        while (seq_idx < total && cycles < 4000) begin
            if (abort_at >= 0 && seq_idx == abort_at) begin
                #3;
                rst_n = 1'b0;
                #1;
                checkOutput("async_reset", all_outs, 0);
                @(posedge clk);
                #1;
                checkOutput("held_reset", all_outs, 0);
                rst_n = 1'b1;
                seq_datain_rdy = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            seq_datain_rdy = seq_random ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checkOutput("seq_flags", {datain_valid, seq_datain_tag, pixel_datain_tag, busy}, 4'b1101);
            if (holding) checkOutput("seq_hold", datain, held_word);
            if (seq_datain_rdy) begin
                captured[seq_idx] = datain;
                checkOutput("seq_word", datain, refWord(seq_idx, cols, k));
                seq_idx++;
                holding = 0;
            end else begin
                held_word = datain;
                holding   = 1;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("seq_count", seq_idx, total);

        seq_datain_rdy = 1'b0;
        #1;
        checkOutput("gap_cycle", {datain_valid, seq_datain_tag, pixel_datain_tag, busy, pix_in_rdy}, 5'b00010);
        @(posedge clk);
        #1;

        cycles = 0;
        while (pix_idx < npix && cycles < 4000) begin
            pix_in           = pixVal(pix_idx);
            pix_in_valid     = pix_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            pixel_datain_rdy = pix_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (poke_start && pix_idx == 5 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            #1;
            checkOutput("pix_flags",
                        {seq_datain_tag, pixel_datain_tag, datain_valid, pix_in_rdy, busy},
                        {1'b0, 1'b1, pix_in_valid, pixel_datain_rdy, 1'b1});
            if (pix_in_valid) checkOutput("pix_data", datain, pixVal(pix_idx));
            if (pix_in_valid && pixel_datain_rdy) pix_idx++;
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        checkOutput("pix_count", pix_idx, npix);

        pix_in           = 16'hDEAD;
        pix_in_valid     = 1'b1;
        pixel_datain_rdy = 1'b1;
        #1;
        checkOutput("done_cycle", {done, busy, pix_in_rdy, datain_valid, pixel_datain_tag}, 5'b11000);
        @(posedge clk);
        #1;
        checkOutput("after_done", {done, busy, datain_valid, pix_in_rdy}, 4'b0000);
        pix_in_valid     = 1'b0;
        pixel_datain_rdy = 1'b0;
        expected_done++;
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        num_rows_cfg     = '0;
        num_cols_cfg     = '0;
        kernel_size_cfg  = '0;
        pix_in           = '0;
        pix_in_valid     = 1'b0;
        seq_datain_rdy   = 1'b0;
        pixel_datain_rdy = 1'b0;

        #12;
        checkOutput("reset_outputs", all_outs, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_outputs", all_outs, 0);

        $display("[TB] cols=10 K=3 rows=10, ready always high");
        runLoad(10, 10, 3, 0, 0, 0, -1);
        for (int i = 0; i < 50; i++) first_run[i] = captured[i];
        checkOutput("word0",  captured[0],  16'h0C00);
        checkOutput("word1",  captured[1],  16'h0002);
        checkOutput("word2",  captured[2],  16'h2200);
        checkOutput("word35", captured[35], 16'h2807);
        checkOutput("word36", captured[36], 16'h0408);
        checkOutput("word37", captured[37], 16'h0207);
        checkOutput("word38", captured[38], 16'h0208);
        checkOutput("word39", captured[39], 16'h1209);
        checkOutput("word40", captured[40], 16'h0000);
        checkOutput("word49", captured[49], 16'h0000);

        $display("[TB] same config, random sequence backpressure");
        runLoad(10, 10, 3, 1, 0, 0, -1);
        for (int i = 0; i < 50; i++) checkOutput("rerun_word", captured[i], first_run[i]);

        $display("[TB] bad configs");
        applyStimulus(9, 9, 12);
        checkOutput("cfg_err_big_k", {cfg_err, busy, datain_valid}, 3'b100);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("cfg_err_quiet", {cfg_err, busy, datain_valid, seq_datain_tag}, 4'b1000);
        end
        applyStimulus(9, 9, 0);
        checkOutput("cfg_err_zero_k", {cfg_err, busy, datain_valid}, 3'b100);
        runLoad(2, 4, 4, 0, 0, 0, -1);

        $display("[TB] pixel gaps and backpressure");
        runLoad(3, 5, 2, 0, 1, 0, -1);

        $display("[TB] reset during sequence, then fresh load");
        runLoad(10, 10, 3, 1, 0, 0, 17);
        runLoad(10, 10, 3, 0, 0, 0, -1);

        $display("[TB] start pulsed during pixel phase");
        runLoad(4, 6, 3, 0, 1, 1, -1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_after_poke", {busy, datain_valid, done}, 3'b000);

        checkOutput("done_pulses", done_count, expected_done);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
